// File: rtl/delay_line_ram.sv
// delay_line_ram: sample delay buffer on a one-write/one-read RAM with fill masking and zero-offset bypass.
// Defining DELAY_LINE_RAM_OUTREG_EN adds an output register stage (latency 2 instead of 1).
module delay_line_ram #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     out_valid,
  output logic                     primed,
  output logic [ADDRESS_WIDTH-1:0] wptr
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] FILL_MAX = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  // Picks the delayed sample: zero when the location has not been written since reset.
  function automatic logic [DATA_WIDTH-1:0] select_sample(
    input logic                  ok,
    input logic                  byp,
    input logic [DATA_WIDTH-1:0] cur,
    input logic [DATA_WIDTH-1:0] stored
  );
    if (!ok)
      return '0;
    else if (byp)
      return cur;
    else
      return stored;
  endfunction

  logic [DATA_WIDTH-1:0]    ram [DEPTH];
  logic [ADDRESS_WIDTH:0]   fill;
  logic [ADDRESS_WIDTH-1:0] raddr;
  logic                     accept;
  logic                     rd_ok;
  logic                     byp;

  assign accept = in_valid & ~rst;
  assign raddr  = wptr - offset;
  assign rd_ok  = ({1'b0, offset} <= fill);
  assign byp    = (offset == '0);

  // ---- stage p0: RAM write, RAM read and capture of the bypass/mask decision ----
  logic [DATA_WIDTH-1:0] rd_p0;
  logic [DATA_WIDTH-1:0] din_p0;
  logic                  byp_p0;
  logic                  ok_p0;
  logic                  vld_p0;

  always_ff @(posedge clk) begin
    if (accept) begin
      ram[wptr] <= din;
      if (!byp)
        rd_p0 <= ram[raddr];
      din_p0 <= din;
      byp_p0 <= byp;
      ok_p0  <= rd_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr   <= '0;
      fill   <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        wptr <= wptr + ADDRESS_WIDTH'(1);
        if (fill != FILL_MAX)
          fill <= fill + (ADDRESS_WIDTH + 1)'(1);
      end
    end
  end

  // ---- stage p1: output register; dout/primed hold across idle cycles ----
  logic [DATA_WIDTH-1:0] dout_p1;
  logic                  vld_p1;
  logic                  primed_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_p1   <= '0;
      vld_p1    <= 1'b0;
      primed_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        dout_p1   <= select_sample(ok_p0, byp_p0, din_p0, rd_p0);
        primed_p1 <= ok_p0;
      end
    end
  end

`ifdef DELAY_LINE_RAM_OUTREG_EN
  // ---- stage p2: optional extra output register ----
  logic [DATA_WIDTH-1:0] dout_p2;
  logic                  vld_p2;
  logic                  primed_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_p2   <= '0;
      vld_p2    <= 1'b0;
      primed_p2 <= 1'b0;
    end else begin
      dout_p2   <= dout_p1;
      vld_p2    <= vld_p1;
      primed_p2 <= primed_p1;
    end
  end

  assign dout      = dout_p2;
  assign out_valid = vld_p2;
  assign primed    = primed_p2;
`else
  assign dout      = dout_p1;
  assign out_valid = vld_p1;
  assign primed    = primed_p1;
`endif

endmodule

// File: tb/tb_delay_line_ram.sv
// Bench for delay_line_ram: directed vector table plus randomized stream against a history-based model,
// run on a 512-deep and an 8-deep instance fed with the same samples.
`timescale 1ns/1ps
module tb_delay_line_ram;
`ifdef DELAY_LINE_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid;
  logic [7:0] din;
  logic [8:0] offset9;
  logic [2:0] offset3;
  logic [7:0] dout9, dout3;
  logic       out_valid9, out_valid3, primed9, primed3;
  logic [8:0] wptr9;
  logic [2:0] wptr3;

  delay_line_ram #(.ADDRESS_WIDTH(9), .DATA_WIDTH(8)) u9 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .offset(offset9),
    .dout(dout9), .out_valid(out_valid9), .primed(primed9), .wptr(wptr9));

  delay_line_ram #(.ADDRESS_WIDTH(3), .DATA_WIDTH(8)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .offset(offset3),
    .dout(dout3), .out_valid(out_valid3), .primed(primed3), .wptr(wptr3));

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic v; logic [7:0] d; logic p;} res_t;
  res_t c_m[2], o1_m[2], o2_m[2];
  logic [7:0] hist [0:8191];
  int count = 0;

  logic [7:0] rec_d9 [64];
  logic [7:0] rec_d3 [64];
  logic       rec_v9 [64];
  logic       rec_p9 [64];
  logic [2:0] rec_w3 [64];
  int rec_n = 0;

  typedef struct {int seg; logic v; logic [7:0] d; logic [8:0] off; logic [7:0] ed; logic ev; logic ep;} vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference read: a sample written k accepts ago is visible iff k <= samples held (capped at depth).
  function automatic res_t model_read(input int depth, input int off, input logic [7:0] d);
    res_t r;
    int fill;
    fill = (count < depth) ? count : depth;
    r.v = 1'b1;
    if (off > fill) begin
      r.d = 8'h00;
      r.p = 1'b0;
    end else begin
      r.p = 1'b1;
      r.d = (off == 0) ? d : hist[count - off];
    end
    return r;
  endfunction

  task automatic cycle(input logic r, input logic v, input logic [7:0] d,
                       input logic [8:0] o9, input logic [2:0] o3);
    res_t e9, e3;
    rst = r; in_valid = v; din = d; offset9 = o9; offset3 = o3;
    for (int k = 0; k < 2; k++) begin
      o2_m[k] = r ? '0 : o1_m[k];
      if (r) o1_m[k] = '0;
      else begin
        o1_m[k].v = c_m[k].v;
        if (c_m[k].v) begin
          o1_m[k].d = c_m[k].d;
          o1_m[k].p = c_m[k].p;
        end
      end
    end
    if (r) begin
      c_m[0] = '0; c_m[1] = '0; count = 0;
    end else if (v) begin
      c_m[0] = model_read(512, int'(o9), d);
      c_m[1] = model_read(8, int'(o3), d);
      hist[count] = d;
      count++;
    end else begin
      c_m[0].v = 1'b0; c_m[1].v = 1'b0;
    end
    @(posedge clk);
    #1;
    e9 = (LAT == 2) ? o2_m[0] : o1_m[0];
    e3 = (LAT == 2) ? o2_m[1] : o1_m[1];
    check("m_dout9", dout9, e9.d);
    check("m_valid9", out_valid9, e9.v);
    check("m_primed9", primed9, e9.p);
    check("m_wptr9", wptr9, count % 512);
    check("m_dout3", dout3, e3.d);
    check("m_valid3", out_valid3, e3.v);
    check("m_primed3", primed3, e3.p);
    check("m_wptr3", wptr3, count % 8);
    if (rec_n < 64) begin
      rec_d9[rec_n] = dout9; rec_v9[rec_n] = out_valid9; rec_p9[rec_n] = primed9;
      rec_d3[rec_n] = dout3; rec_w3[rec_n] = wptr3;
      rec_n++;
    end
  endtask

  initial begin
    int n;
    int idx[16];
    logic [7:0] exp_d;
    logic [7:0] rs_d[3];
    logic       rs_p[3];

    tbl[0]  = '{0, 1'b1, 8'd10,  9'd3, 8'd0,  1'b1, 1'b0};
    tbl[1]  = '{0, 1'b1, 8'd11,  9'd3, 8'd0,  1'b1, 1'b0};
    tbl[2]  = '{0, 1'b1, 8'd12,  9'd3, 8'd0,  1'b1, 1'b0};
    tbl[3]  = '{0, 1'b1, 8'd13,  9'd3, 8'd10, 1'b1, 1'b1};
    tbl[4]  = '{0, 1'b1, 8'd14,  9'd3, 8'd11, 1'b1, 1'b1};
    tbl[5]  = '{1, 1'b1, 8'h5A,  9'd0, 8'h5A, 1'b1, 1'b1};
    tbl[6]  = '{1, 1'b1, 8'hA5,  9'd0, 8'hA5, 1'b1, 1'b1};
    tbl[7]  = '{2, 1'b1, 8'd3,   9'd1, 8'd0,  1'b1, 1'b0};
    tbl[8]  = '{2, 1'b0, 8'hEE,  9'd1, 8'd0,  1'b0, 1'b0};
    tbl[9]  = '{2, 1'b0, 8'hEE,  9'd1, 8'd0,  1'b0, 1'b0};
    tbl[10] = '{2, 1'b1, 8'd4,   9'd1, 8'd3,  1'b1, 1'b1};

    c_m[0] = '0; c_m[1] = '0; o1_m[0] = '0; o1_m[1] = '0; o2_m[0] = '0; o2_m[1] = '0;
    cycle(1'b1, 1'b0, 8'h00, 9'd0, 3'd0);
    cycle(1'b1, 1'b1, 8'h33, 9'd0, 3'd0);
    check("reset_dout", dout9, 0);
    check("reset_valid", out_valid9, 0);
    check("reset_primed", primed9, 0);
    check("reset_wptr", wptr9, 0);

    for (int s = 0; s < 3; s++) begin
      cycle(1'b1, 1'b0, 8'h00, 9'd0, 3'd0);
      rec_n = 0;
      n = 0;
      for (int i = 0; i < 11; i++) begin
        if (tbl[i].seg == s) begin
          idx[n] = i;
          n++;
          cycle(1'b0, tbl[i].v, tbl[i].d, tbl[i].off, tbl[i].off[2:0]);
        end
      end
      for (int j = 0; j < LAT; j++) cycle(1'b0, 1'b0, 8'h00, 9'd0, 3'd0);
      for (int j = 0; j < n; j++) begin
        check("tbl_dout", rec_d9[j + LAT], tbl[idx[j]].ed);
        check("tbl_valid", rec_v9[j + LAT], tbl[idx[j]].ev);
        check("tbl_primed", rec_p9[j + LAT], tbl[idx[j]].ep);
      end
      if (s == 2) check("gap_wptr", wptr9, 2);
    end

    cycle(1'b1, 1'b0, 8'h00, 9'd0, 3'd0);
    rec_n = 0;
    for (int k = 1; k <= 20; k++) cycle(1'b0, 1'b1, 8'(k), 9'd7, 3'd7);
    for (int j = 0; j < LAT; j++) cycle(1'b0, 1'b0, 8'h00, 9'd0, 3'd0);
    for (int k = 1; k <= 20; k++) begin
      exp_d = (k >= 8) ? 8'(k - 7) : 8'd0;
      check("wrap_dout", rec_d3[k - 1 + LAT], exp_d);
      check("wrap_wptr", rec_w3[k - 1], k % 8);
    end

    cycle(1'b1, 1'b0, 8'h00, 9'd0, 3'd0);
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 8'($urandom_range(1, 255)), 9'd2, 3'd2);
    cycle(1'b1, 1'b1, 8'h77, 9'd2, 3'd2);
    check("rst_mid_dout", dout9, 0);
    check("rst_mid_valid", out_valid9, 0);
    check("rst_mid_primed", primed9, 0);
    check("rst_mid_wptr", wptr9, 0);
    rec_n = 0;
    rs_d[0] = 8'd0; rs_d[1] = 8'd0; rs_d[2] = 8'd7;
    rs_p[0] = 1'b0; rs_p[1] = 1'b0; rs_p[2] = 1'b1;
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 8'(7 + k), 9'd2, 3'd2);
    for (int j = 0; j < LAT; j++) cycle(1'b0, 1'b0, 8'h00, 9'd0, 3'd0);
    for (int k = 0; k < 3; k++) begin
      check("rst_seq_dout", rec_d9[k + LAT], rs_d[k]);
      check("rst_seq_primed", rec_p9[k + LAT], rs_p[k]);
    end

    for (int t = 0; t < 3000; t++) begin
      logic r, v;
      logic [8:0] o9;
      int mode;
      r = ($urandom_range(0, 149) == 0) || (count > 8000);
      v = ($urandom_range(0, 3) != 0);
      mode = $urandom_range(0, 3);
      if (mode == 0) o9 = 9'($urandom_range(0, 511));
      else if (mode == 1) o9 = 9'((count > 511 ? 511 : count) + $urandom_range(0, 2) - 1);
      else if (mode == 2) o9 = 9'd0;
      else o9 = 9'($urandom_range(0, 8));
      cycle(r, v, 8'($urandom_range(0, 255)), o9, 3'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
